// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem request tracker and 2-entry buffer toward decode.
// Optional feature macro ILLEGAL_OP_TRAP_EN: traps unsupported opcodes at the buffer head.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [31:0]       if_instr,
    output logic [5:0]        if_opcode,
    output logic [ADDR_W-1:0] if_pc,
`ifdef ILLEGAL_OP_TRAP_EN
    output logic              illegal_op,
`endif
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc
);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DROP} state_t;

    state_t                 state_reg, state_next;
    logic [ADDR_W-1:0]      pc_reg, pc_next;
    logic [ADDR_W-1:0]      req_pc_reg, req_pc_next;
    logic                   req_reg, req_next;
    logic [1:0]             vld_reg, vld_next;
    logic [1:0][31:0]       instr_reg, instr_next;
    logic [1:0][ADDR_W-1:0] epc_reg, epc_next;
    logic                   if_valid_reg, if_valid_next;
    logic                   head_bad;
    logic                   accept, push, pop;
    logic                   unused_ok;

    assign accept = imem_req & imem_ready;
    assign push   = (state_reg == S_WAIT) & imem_rvalid & ~redirect_valid;
    assign pop    = if_valid_reg & if_ready & ~redirect_valid;

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        req_pc_next = req_pc_reg;
        case (state_reg)
            S_FETCH: if (accept) begin
                state_next  = S_WAIT;
                pc_next     = pc_reg + ADDR_W'(4);
                req_pc_next = pc_reg;
            end
            // A response landing in the redirect cycle retires the request, so no DROP is needed.
            S_WAIT:  if (imem_rvalid) state_next = S_FETCH;
                     else if (redirect_valid) state_next = S_DROP;
            S_DROP:  if (imem_rvalid) state_next = S_FETCH;
            default: state_next = S_FETCH;
        endcase
        if (redirect_valid)
            pc_next = {redirect_pc[ADDR_W-1:2], 2'b00};
    end

    always_comb begin
        vld_next   = pop ? {1'b0, vld_reg[1]} : vld_reg;
        instr_next = instr_reg;
        epc_next   = epc_reg;
        if (pop) begin
            instr_next[0] = instr_reg[1];
            epc_next[0]   = epc_reg[1];
        end
        if (push) begin
            if (!vld_next[0]) begin
                vld_next[0]   = 1'b1;
                instr_next[0] = imem_rdata;
                epc_next[0]   = req_pc_reg;
            end else begin
                vld_next[1]   = 1'b1;
                instr_next[1] = imem_rdata;
                epc_next[1]   = req_pc_reg;
            end
        end
        if (redirect_valid)
            vld_next = '0;
    end

`ifdef ILLEGAL_OP_TRAP_EN
    localparam int NUM_OPS = 7;
    localparam logic [NUM_OPS*6-1:0] LEGAL_OPS = {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                                  6'b001000, 6'b100001, 6'b100101};
    logic [NUM_OPS-1:0] op_hit;
    logic               illegal_op_reg;

    for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_op
        assign op_hit[gi] = (instr_next[0][31:26] == LEGAL_OPS[gi*6 +: 6]);
    end
    assign head_bad = vld_next[0] & ~(|op_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) illegal_op_reg <= 1'b0;
        else        illegal_op_reg <= head_bad;
    end
    assign illegal_op = illegal_op_reg;
`else
    assign head_bad = 1'b0;
`endif

    // Count + outstanding < 2 reduces to "slot 1 free" because FETCH never has a request in flight.
    assign if_valid_next = vld_next[0] & ~head_bad;
    assign req_next      = (state_next == S_FETCH) & ~vld_next[1] & ~head_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_FETCH;
            pc_reg       <= RESET_PC;
            req_pc_reg   <= '0;
            req_reg      <= 1'b0;
            vld_reg      <= '0;
            instr_reg    <= '0;
            epc_reg      <= '0;
            if_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            req_pc_reg   <= req_pc_next;
            req_reg      <= req_next;
            vld_reg      <= vld_next;
            instr_reg    <= instr_next;
            epc_reg      <= epc_next;
            if_valid_reg <= if_valid_next;
        end
    end

    assign imem_req  = req_reg & ~redirect_valid;
    assign imem_addr = pc_reg;
    assign if_valid  = if_valid_reg;
    assign if_instr  = instr_reg[0];
    assign if_opcode = instr_reg[0][31:26];
    assign if_pc     = epc_reg[0];
    assign unused_ok = ^redirect_pc[1:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: memory responder plus in-order PC/instruction model.
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        imem_req, imem_ready, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        if_valid, if_ready;
    logic [31:0] if_instr, if_pc;
    logic [5:0]  if_opcode;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        w_req, w_ready, w_rvalid, w_if_valid, w_if_ready, w_redirect_valid;
    logic [31:0] w_addr, w_rdata, w_if_instr, w_if_pc, w_redirect_pc;
    logic [5:0]  w_if_opcode;
`ifdef ILLEGAL_OP_TRAP_EN
    logic        illegal_op, w_illegal_op;
`endif

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
        .if_opcode(if_opcode), .if_pc(if_pc),
`ifdef ILLEGAL_OP_TRAP_EN
        .illegal_op(illegal_op),
`endif
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ready(w_ready),
        .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
        .if_valid(w_if_valid), .if_ready(w_if_ready), .if_instr(w_if_instr),
        .if_opcode(w_if_opcode), .if_pc(w_if_pc),
`ifdef ILLEGAL_OP_TRAP_EN
        .illegal_op(w_illegal_op),
`endif
        .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_tab [logic [31:0]];
    int unsigned p_ready, p_if_ready, p_redir, lat_min, lat_max;
    bit          redir_req;
    logic [31:0] redir_tgt;

    bit          pend;
    int unsigned pend_cnt;
    logic [31:0] pend_addr;

    logic [31:0] exp_fetch, exp_pop, prev_pc, prev_instr;
    int          live, n_accept, n_pop;
    bit          prev_stall, prev_redir, obs_valid, obs_req, obs_ill;
    logic [31:0] acc_q[$];
    logic [31:0] pop_pc_q[$];
    logic [5:0]  pop_op_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        if (mem_tab.exists(a)) return mem_tab[a];
        w = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
`ifdef ILLEGAL_OP_TRAP_EN
        w[31:26] = 6'b100011;
`endif
        return w;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; if_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        w_ready = 1'b0; w_rvalid = 1'b0; w_rdata = '0; w_if_ready = 1'b0;
        w_redirect_valid = 1'b0; w_redirect_pc = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pend = 1'b0; live = 0; n_accept = 0; n_pop = 0;
        exp_fetch = 32'h0; exp_pop = 32'h0;
        prev_stall = 1'b0; prev_redir = 1'b0; redir_req = 1'b0;
        acc_q.delete(); pop_pc_q.delete(); pop_op_q.delete(); mem_tab.delete();
        p_redir = 0; lat_min = 1; lat_max = 1;
    endtask

    // One clock: drive at negedge, sample #1 later, check against the in-order model.
    task automatic step();
        bit          rv, acc, pop;
        logic [31:0] w, t;
        @(negedge clk);
        rv = pend && (pend_cnt == 0);
        if (pend && pend_cnt > 0) pend_cnt--;
        imem_rvalid = rv;
        imem_rdata  = rv ? mem_word(pend_addr) : $urandom;
        imem_ready  = ($urandom_range(99) < p_ready);
        if_ready    = ($urandom_range(99) < p_if_ready);
        if (redir_req) begin
            redirect_valid = 1'b1; redirect_pc = redir_tgt; redir_req = 1'b0;
        end else begin
            redirect_valid = ($urandom_range(999) < p_redir);
            redirect_pc    = $urandom;
        end
        #1;
        obs_valid = if_valid; obs_req = imem_req;
`ifdef ILLEGAL_OP_TRAP_EN
        obs_ill = illegal_op;
`else
        obs_ill = 1'b0;
`endif
        if (prev_redir) begin
            checks++;
            if (if_valid !== 1'b0) begin errors++; $display("FAIL flush: if_valid=%b required 0", if_valid); end
        end
        if (prev_stall) begin
            checks++;
            if (if_valid !== 1'b1 || if_pc !== prev_pc || if_instr !== prev_instr) begin
                errors++;
                $display("FAIL hold: valid=%b pc=%h instr=%h required 1 %h %h", if_valid, if_pc, if_instr, prev_pc, prev_instr);
            end
        end
        if (redirect_valid) begin
            checks++;
            if (imem_req !== 1'b0) begin errors++; $display("FAIL req_in_redirect: imem_req=%b required 0", imem_req); end
        end
        acc = imem_req && imem_ready;
        if (acc) begin
            checks++;
            if (imem_addr !== exp_fetch) begin errors++; $display("FAIL fetch_addr: got %h required %h", imem_addr, exp_fetch); end
            checks++;
            if (pend || live >= 2) begin errors++; $display("FAIL reserve: outstanding=%0d live=%0d required 0 and <2", pend, live); end
            acc_q.push_back(imem_addr);
            exp_fetch = exp_fetch + 32'd4;
            live++; n_accept++;
        end
        pop = if_valid && if_ready && !redirect_valid;
        if (pop) begin
            w = mem_word(exp_pop);
            checks++;
            if (if_pc !== exp_pop || if_instr !== w || if_opcode !== w[31:26]) begin
                errors++;
                $display("FAIL pop: pc=%h instr=%h op=%b required %h %h %b", if_pc, if_instr, if_opcode, exp_pop, w, w[31:26]);
            end
            pop_pc_q.push_back(if_pc); pop_op_q.push_back(if_opcode);
            exp_pop = exp_pop + 32'd4;
            live--; n_pop++;
        end
        if (rv) pend = 1'b0;
        if (acc) begin
            pend = 1'b1; pend_addr = imem_addr;
            pend_cnt = $urandom_range(lat_max - 1, lat_min - 1);
        end
        if (redirect_valid) begin
            t = {redirect_pc[31:2], 2'b00};
            exp_fetch = t; exp_pop = t; live = 0;
        end
        prev_stall = if_valid && !if_ready && !redirect_valid;
        prev_pc = if_pc; prev_instr = if_instr; prev_redir = redirect_valid;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        checks++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0 || if_instr !== 32'h0 || if_pc !== 32'h0 || if_opcode !== 6'h0) begin
            errors++;
            $display("FAIL reset_state: req=%b valid=%b instr=%h pc=%h op=%b required all 0", imem_req, if_valid, if_instr, if_pc, if_opcode);
        end
        do_reset();
        p_ready = 100; p_if_ready = 0;
        repeat (6) step();
        checks++;
        if (obs_valid !== 1'b1 || live != 2) begin errors++; $display("FAIL fill: valid=%b live=%0d required 1 2", obs_valid, live); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (if_valid !== 1'b0 || imem_req !== 1'b0 || if_pc !== 32'h0) begin
            errors++; $display("FAIL async_reset: valid=%b req=%b pc=%h required 0 0 0", if_valid, imem_req, if_pc);
        end
    endtask

    task automatic test_first_fetch();
        do_reset();
        p_ready = 100; p_if_ready = 100; lat_min = 3; lat_max = 3;
        step();
        checks++;
        if (obs_req !== 1'b1 || n_accept != 1 || acc_q.size() == 0 || acc_q[0] !== 32'h0) begin
            errors++; $display("FAIL first_req: req=%b accepts=%0d required 1 1 at addr 0", obs_req, n_accept);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs_valid !== 1'b0) begin errors++; $display("FAIL early_valid: cycle %0d valid=%b required 0", i, obs_valid); end
        end
        step();
        checks++;
        if (obs_valid !== 1'b1) begin errors++; $display("FAIL first_valid: valid=%b required 1", obs_valid); end
    endtask

    task automatic test_stream();
        logic [5:0] ops [3];
        int n;
        ops[0] = 6'b100011; ops[1] = 6'b001000; ops[2] = 6'b000000;
        do_reset();
        mem_tab[32'h0] = 32'h8C01_0004; mem_tab[32'h4] = 32'h2002_0001; mem_tab[32'h8] = 32'h0022_1820;
        p_ready = 100; p_if_ready = 100;
        n = 0;
        while (n_pop < 3 && n < 30) begin step(); n++; end
        checks++;
        if (n != 7) begin errors++; $display("FAIL stream_cycles: took %0d cycles required 7", n); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (pop_pc_q.size() <= i || pop_pc_q[i] !== 32'(i * 4) || pop_op_q[i] !== ops[i]) begin
                errors++; $display("FAIL stream_%0d: popped %0d entries, required pc %h op %b", i, pop_pc_q.size(), i * 4, ops[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        p_ready = 100; p_if_ready = 0;
        repeat (12) step();
        checks++;
        if (n_accept != 2 || obs_req !== 1'b0) begin
            errors++; $display("FAIL bp_accepts: accepts=%0d req=%b required 2 0", n_accept, obs_req);
        end
        p_if_ready = 100;
        n = 0;
        while (n_accept < 3 && n < 20) begin step(); n++; end
        checks++;
        if (pop_pc_q.size() < 2 || pop_pc_q[0] !== 32'h0 || pop_pc_q[1] !== 32'h4) begin
            errors++; $display("FAIL bp_order: popped %0d entries required pcs 0,4", pop_pc_q.size());
        end
        checks++;
        if (acc_q.size() != 3 || acc_q[2] !== 32'h8) begin
            errors++; $display("FAIL bp_resume: accepts=%0d required third addr 00000008", acc_q.size());
        end
    endtask

    task automatic test_redirect();
        int n;
        do_reset();
        p_ready = 100; p_if_ready = 100; lat_min = 3; lat_max = 3;
        step();
        redir_req = 1'b1; redir_tgt = 32'h0000_0043;
        step();
        n = 0;
        while (n_pop < 1 && n < 30) begin step(); n++; end
        checks++;
        if (acc_q.size() < 2 || acc_q[1] !== 32'h40) begin
            errors++; $display("FAIL redir_addr: accepts=%0d required second addr 00000040", acc_q.size());
        end
        checks++;
        if (pop_pc_q.size() < 1 || pop_pc_q[0] !== 32'h40) begin
            errors++; $display("FAIL redir_pc: popped %0d entries required first pc 00000040", pop_pc_q.size());
        end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        @(negedge clk); #1;
        checks++;
        if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
            errors++; $display("FAIL wrap_first: req=%b addr=%h required 1 fffffffc", w_req, w_addr);
        end
        w_ready = 1'b1;
        @(negedge clk);
        w_ready = 1'b0; w_rvalid = 1'b1; w_rdata = 32'h8C00_0000;
        #1;
        checks++;
        if (w_req !== 1'b0) begin errors++; $display("FAIL wrap_wait: req=%b required 0", w_req); end
        @(negedge clk);
        w_rvalid = 1'b0;
        #1;
        checks++;
        if (w_req !== 1'b1 || w_addr !== 32'h0) begin
            errors++; $display("FAIL wrap_next: req=%b addr=%h required 1 00000000", w_req, w_addr);
        end
        checks++;
        if (w_if_valid !== 1'b1 || w_if_pc !== 32'hFFFF_FFFC || w_if_instr !== 32'h8C00_0000) begin
            errors++; $display("FAIL wrap_head: valid=%b pc=%h instr=%h required 1 fffffffc 8c000000", w_if_valid, w_if_pc, w_if_instr);
        end
    endtask

    task automatic test_random();
        do_reset();
        p_ready = 70; p_if_ready = 60; p_redir = 30; lat_min = 1; lat_max = 3;
        repeat (800) step();
        checks++;
        if (n_pop < 40) begin errors++; $display("FAIL random_progress: pops=%0d required >=40", n_pop); end
    endtask

`ifdef ILLEGAL_OP_TRAP_EN
    task automatic test_trap();
        int n;
        do_reset();
        mem_tab[32'h0] = 32'hFC00_0000;
        p_ready = 100; p_if_ready = 100;
        n = 0;
        obs_ill = 1'b0;
        while (!obs_ill && n < 10) begin step(); n++; end
        checks++;
        if (obs_ill !== 1'b1 || obs_valid !== 1'b0) begin
            errors++; $display("FAIL trap_set: illegal=%b valid=%b required 1 0", obs_ill, obs_valid);
        end
        repeat (5) begin
            step();
            checks++;
            if (obs_req !== 1'b0 || obs_ill !== 1'b1) begin
                errors++; $display("FAIL trap_halt: req=%b illegal=%b required 0 1", obs_req, obs_ill);
            end
        end
        redir_req = 1'b1; redir_tgt = 32'h0000_0080;
        step();
        step();
        checks++;
        if (obs_ill !== 1'b0 || acc_q.size() != 2 || acc_q[1] !== 32'h80) begin
            errors++; $display("FAIL trap_clear: illegal=%b accepts=%0d required 0 and addr 00000080", obs_ill, acc_q.size());
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; if_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        w_ready = 1'b0; w_rvalid = 1'b0; w_rdata = '0; w_if_ready = 1'b0;
        w_redirect_valid = 1'b0; w_redirect_pc = '0;
        pend = 1'b0; pend_cnt = 0; pend_addr = '0; redir_req = 1'b0; redir_tgt = '0;
        p_ready = 0; p_if_ready = 0; p_redir = 0; lat_min = 1; lat_max = 1;
        test_reset();
        test_first_fetch();
        test_stream();
        test_backpressure();
        test_redirect();
        test_pc_wrap();
        test_random();
`ifdef ILLEGAL_OP_TRAP_EN
        test_trap();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
